pwm_multichannel: RTL and testbench

//   NUM_CH-channel PWM generator with programmable period (TOP), prescaler and

---
 rtl/pwm_multichannel_if.sv | 29 ++
 rtl/pwm_multichannel.sv | 112 +++++++++++
 tb/tb_pwm_multichannel.sv | 270 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/pwm_multichannel_if.sv
// Control/register bus for pwm_multichannel: shadow writes, timing setup and channel enables.
interface pwm_multichannel_if #(
  parameter int unsigned NUM_CH = 16,
  parameter int unsigned CNT_W  = 8,
  parameter int unsigned PRE_W  = 8
);
  localparam int unsigned CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  logic              duty_we;
  logic [CH_W-1:0]   duty_ch;
  logic [CNT_W-1:0]  duty_wdata;
  logic              top_we;
  logic [CNT_W-1:0]  top_wdata;
  logic              center_mode;
  logic [PRE_W-1:0]  prescale;
  logic              restart;
  logic [NUM_CH-1:0] en_out;
  logic [NUM_CH-1:0] en_pwm;

  modport master (
    output duty_we, duty_ch, duty_wdata, top_we, top_wdata,
           center_mode, prescale, restart, en_out, en_pwm
  );

  modport slave (
    input  duty_we, duty_ch, duty_wdata, top_we, top_wdata,
           center_mode, prescale, restart, en_out, en_pwm
  );
endinterface

// File: rtl/pwm_multichannel.sv
// NUM_CH-channel PWM with prescaler, edge/center-aligned counting and shadowed
// duty/TOP registers that commit only at a period boundary or on restart.
module pwm_multichannel #(
  parameter int unsigned NUM_CH = 16,
  parameter int unsigned CNT_W  = 8,
  parameter int unsigned PRE_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  pwm_multichannel_if.slave bus,
  output logic [NUM_CH-1:0] out,
  output logic              period_start
);
  localparam int unsigned CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam logic [CH_W:0] NUM_CH_L = (CH_W+1)'(NUM_CH);

  typedef enum logic {DIR_UP, DIR_DOWN} dir_t;

  dir_t              dir_q, dir_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [PRE_W-1:0]  pre_q, pre_d;
  logic [CNT_W-1:0]  top_sh, top_act;
  logic              mode_act;
  logic [CNT_W-1:0]  duty_sh  [NUM_CH];
  logic [CNT_W-1:0]  duty_act [NUM_CH];
  logic              tick_c, commit_c, ch_ok_c;
  logic [NUM_CH-1:0] pwm_c;

  assign ch_ok_c = ({1'b0, bus.duty_ch} < NUM_CH_L);

  // Prescaler, counter and direction next-state; commit_c marks a period boundary.
  always_comb begin
    pre_d    = pre_q;
    cnt_d    = cnt_q;
    dir_d    = dir_q;
    tick_c   = 1'b0;
    commit_c = 1'b0;
    if (bus.restart) begin
      pre_d    = '0;
      cnt_d    = '0;
      commit_c = 1'b1;
    end else begin
      // >= so that lowering prescale below pre_q wraps immediately
      tick_c = (pre_q >= bus.prescale);
      pre_d  = tick_c ? '0 : pre_q + PRE_W'(1);
      if (tick_c) begin
        if (!mode_act || top_act <= CNT_W'(1)) begin
          if (cnt_q >= top_act) begin
            cnt_d    = '0;
            commit_c = 1'b1;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end else if (dir_q == DIR_UP) begin
          if (cnt_q >= top_act) begin
            cnt_d = top_act - CNT_W'(1);
            dir_d = DIR_DOWN;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end else begin
          if (cnt_q <= CNT_W'(1)) begin
            cnt_d    = '0;
            commit_c = 1'b1;
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
      end
    end
    if (commit_c) dir_d = DIR_UP;
  end

  // Per-channel compare against the committed duty (duty > TOP gives 100%).
  always_comb begin
    pwm_c = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      pwm_c[i] = ({1'b0, cnt_q} < {1'b0, duty_act[i]});
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q        <= '0;
      pre_q        <= '0;
      dir_q        <= DIR_UP;
      top_sh       <= '1;
      top_act      <= '1;
      mode_act     <= 1'b0;
      out          <= '0;
      period_start <= 1'b0;
      for (int i = 0; i < NUM_CH; i++) begin
        duty_sh[i]  <= '0;
        duty_act[i] <= '0;
      end
    end else begin
      cnt_q        <= cnt_d;
      pre_q        <= pre_d;
      dir_q        <= dir_d;
      period_start <= commit_c;
      out          <= bus.en_out & (~bus.en_pwm | pwm_c);
      if (commit_c) begin
        duty_act <= duty_sh;
        top_act  <= top_sh;
        mode_act <= bus.center_mode;
      end
      // Shadow writes land after the commit reads, so a boundary-cycle write waits a period
      if (bus.duty_we && ch_ok_c) duty_sh[bus.duty_ch] <= bus.duty_wdata;
      if (bus.top_we) top_sh <= bus.top_wdata;
    end
  end
endmodule

// File: tb/tb_pwm_multichannel.sv
// Randomized bench for pwm_multichannel: a period-position reference model checked
// every cycle, plus directed scenarios with hand-computed duty/period figures.
module tb_pwm_multichannel;
  localparam int unsigned NUM_CH = 12;
  localparam int unsigned CNT_W  = 8;
  localparam int unsigned PRE_W  = 8;
  localparam int unsigned CH_W   = $clog2(NUM_CH);

  logic              clk = 1'b0;
  logic              rst;
  logic [NUM_CH-1:0] out;
  logic              period_start;

  int errors = 0;
  int checks = 0;
  bit chk_en = 1'b0;

  pwm_multichannel_if #(.NUM_CH(NUM_CH), .CNT_W(CNT_W), .PRE_W(PRE_W)) bus ();

  pwm_multichannel #(.NUM_CH(NUM_CH), .CNT_W(CNT_W), .PRE_W(PRE_W)) dut (
    .clk(clk), .rst(rst), .bus(bus), .out(out), .period_start(period_start)
  );

  always #5 clk = ~clk;

  // Reference model: position within the period instead of an up/down counter.
  int m_sh_duty [NUM_CH];
  int m_act_duty[NUM_CH];
  int m_sh_top, m_act_top, m_mode, m_pos, m_pre, m_c;
  bit m_commit, m_tick;
  logic [NUM_CH-1:0] m_out;
  logic              m_ps;

  function automatic int period_len();
    if (m_mode != 0) return (m_act_top == 0) ? 1 : 2 * m_act_top;
    return m_act_top + 1;
  endfunction

  function automatic int cur_cnt();
    if (m_mode != 0 && m_pos > m_act_top) return 2 * m_act_top - m_pos;
    return m_pos;
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_CH; i++) begin
        m_sh_duty[i]  = 0;
        m_act_duty[i] = 0;
      end
      m_sh_top = 255; m_act_top = 255; m_mode = 0; m_pos = 0; m_pre = 0;
      m_out = '0; m_ps = 1'b0;
    end else begin
      m_c = cur_cnt();
      for (int i = 0; i < NUM_CH; i++)
        m_out[i] = bus.en_out[i] && (!bus.en_pwm[i] || (m_c < m_act_duty[i]));
      m_commit = 1'b0;
      if (bus.restart) begin
        m_pos = 0; m_pre = 0; m_commit = 1'b1;
      end else begin
        m_tick = (m_pre >= int'(bus.prescale));
        m_pre  = m_tick ? 0 : m_pre + 1;
        if (m_tick) begin
          m_pos++;
          if (m_pos >= period_len()) begin
            m_pos = 0; m_commit = 1'b1;
          end
        end
      end
      m_ps = m_commit;
      if (m_commit) begin
        for (int i = 0; i < NUM_CH; i++) m_act_duty[i] = m_sh_duty[i];
        m_act_top = m_sh_top;
        m_mode    = int'(bus.center_mode);
      end
      if (bus.duty_we && int'(bus.duty_ch) < NUM_CH) m_sh_duty[bus.duty_ch] = int'(bus.duty_wdata);
      if (bus.top_we) m_sh_top = int'(bus.top_wdata);
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      checks++;
      if (out !== m_out) begin
        errors++;
        $display("FAIL out @%0t: got %h expected %h", $time, out, m_out);
      end
      checks++;
      if (period_start !== m_ps) begin
        errors++;
        $display("FAIL period_start @%0t: got %b expected %b", $time, period_start, m_ps);
      end
    end
  end

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check(input string name, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  task automatic wr_duty(input int ch, input int v);
    bus.duty_we = 1'b1; bus.duty_ch = CH_W'(ch); bus.duty_wdata = CNT_W'(v);
    step();
    bus.duty_we = 1'b0;
  endtask

  task automatic wr_top(input int v);
    bus.top_we = 1'b1; bus.top_wdata = CNT_W'(v);
    step();
    bus.top_we = 1'b0;
  endtask

  task automatic do_restart();
    bus.restart = 1'b1;
    step();
    bus.restart = 1'b0;
  endtask

  task automatic measure(input int ch, input int n, output int hi, output int pulses);
    hi = 0; pulses = 0;
    repeat (n) begin
      step();
      hi += int'(out[ch]);
      pulses += int'(period_start);
    end
  endtask

  // Cycles from the next (or current) period_start pulse to the one after it.
  task automatic ps_interval(output int n);
    int k = 0;
    while (!period_start && k < 2000) begin step(); k++; end
    n = 0;
    do begin step(); n++; end while (!period_start && n < 2000);
  endtask

  task automatic wait_ps();
    int k = 0;
    do begin step(); k++; end while (!period_start && k < 2000);
    if (!period_start) check("wait_ps timeout", 0, 1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int hi, pulses, n;
    rst = 1'b1;
    bus.duty_we = 1'b0; bus.duty_ch = '0; bus.duty_wdata = '0;
    bus.top_we = 1'b0; bus.top_wdata = '0; bus.center_mode = 1'b0;
    bus.prescale = '0; bus.restart = 1'b0; bus.en_out = '0; bus.en_pwm = '0;
    step(2);
    chk_en = 1'b1;
    check("reset out", int'(out), 0);
    check("reset period_start", int'(period_start), 0);
    rst = 1'b0;

    // Edge, TOP=255, duty 64 on ch0
    wr_top(255);
    wr_duty(0, 64);
    bus.en_out = '1; bus.en_pwm = '1;
    do_restart();
    check("restart pulse", int'(period_start), 1);
    step();
    measure(0, 256, hi, pulses);
    check("t1 high clks", hi, 64);
    check("t1 pulses", pulses, 1);

    // Edge, TOP=9, prescale 1, duty 5 on ch3
    wr_top(9); wr_duty(3, 5);
    bus.prescale = PRE_W'(1);
    do_restart();
    step(2);
    measure(3, 20, hi, pulses);
    check("t2 high clks", hi, 10);
    ps_interval(n);
    check("t2 period", n, 20);

    // Center, TOP=8, duty 2 on ch1: cnt 0 once and cnt 1 twice per period
    wr_top(8); wr_duty(1, 2);
    bus.prescale = '0; bus.center_mode = 1'b1;
    do_restart();
    step();
    measure(1, 16, hi, pulses);
    check("t3 high ticks", hi, 3);
    check("t3 pulses", pulses, 1);
    ps_interval(n);
    check("t3 period", n, 16);

    // Mid-period and boundary-cycle duty updates on ch2
    bus.center_mode = 1'b0;
    wr_top(255); wr_duty(2, 50);
    do_restart();
    step(100);
    wr_duty(2, 200);
    wait_ps();
    measure(2, 256, hi, pulses);
    check("t4 mid write next period", hi, 200);
    step(255);
    bus.duty_we = 1'b1; bus.duty_ch = CH_W'(2); bus.duty_wdata = CNT_W'(30);
    step();
    bus.duty_we = 1'b0;
    check("t4 boundary pulse", int'(period_start), 1);
    measure(2, 256, hi, pulses);
    check("t4 boundary write held", hi, 200);
    measure(2, 256, hi, pulses);
    check("t4 boundary write 2nd", hi, 30);

    // Constant-level cases over 3 periods of TOP=9
    wr_top(9); wr_duty(4, 0); wr_duty(5, 10); wr_duty(6, 5); wr_duty(7, 5);
    bus.en_pwm[6] = 1'b0; bus.en_out[7] = 1'b0;
    do_restart();
    step();
    measure(4, 30, hi, pulses); check("t5 duty0", hi, 0);
    measure(5, 30, hi, pulses); check("t5 duty top+1", hi, 30);
    measure(6, 30, hi, pulses); check("t5 en_pwm off", hi, 30);
    measure(7, 30, hi, pulses); check("t5 en_out off", hi, 0);

    // Restart mid-period, then reset mid-period
    bus.en_out = '1; bus.en_pwm = '1;
    wr_top(255);
    do_restart();
    step(100);
    do_restart();
    check("t6 restart pulse", int'(period_start), 1);
    ps_interval(n);
    check("t6 period after restart", n, 256);
    step(50);
    wr_duty(0, 77);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("t6 rst out", int'(out), 0);
    check("t6 rst period_start", int'(period_start), 0);
    step(20);
    check("t6 duty cleared", int'(out), 0);

    // Randomized traffic, checked cycle by cycle against the model
    for (int cyc = 0; cyc < 4000; cyc++) begin
      bus.duty_we    = ($urandom_range(3) == 0);
      bus.duty_ch    = CH_W'($urandom_range(15));
      bus.duty_wdata = CNT_W'($urandom_range(1) ? $urandom_range(15) : $urandom_range(255));
      bus.top_we     = ($urandom_range(39) == 0);
      bus.top_wdata  = CNT_W'(($urandom_range(3) == 0) ? $urandom_range(255) : $urandom_range(12));
      if ($urandom_range(49) == 0) bus.center_mode = ~bus.center_mode;
      if ($urandom_range(59) == 0) bus.prescale = PRE_W'($urandom_range(3));
      bus.restart = ($urandom_range(299) == 0);
      if ($urandom_range(99) == 0) bus.en_out = NUM_CH'($urandom);
      if ($urandom_range(99) == 0) bus.en_pwm = NUM_CH'($urandom);
      rst = ($urandom_range(1499) == 0);
      step();
    end
    rst = 1'b0; bus.duty_we = 1'b0; bus.top_we = 1'b0; bus.restart = 1'b0;
    step(2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
